// File: rtl/pattern_gen_if.sv
// Pixel-side bundle for the pattern generator: coordinates, sync and
// data-enable from the display timing block in, registered VGA pins out.
interface pattern_gen_if #(
    parameter int CORDW = 10,
    parameter int CHANW = 4
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             frame;
    logic [2:0]       mode;
    logic             vga_hsync;
    logic             vga_vsync;
    logic [CHANW-1:0] vga_r;
    logic [CHANW-1:0] vga_g;
    logic [CHANW-1:0] vga_b;

    modport master (
        output sx, sy, hsync, vsync, de, frame, mode,
        input  vga_hsync, vga_vsync, vga_r, vga_g, vga_b
    );

    modport slave (
        input  sx, sy, hsync, vsync, de, frame, mode,
        output vga_hsync, vga_vsync, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/pattern_gen.sv
// VGA test-pattern generator: square, bars, checker, scrolling gradient and
// LFSR noise. Mode, scroll offset and LFSR seed only change on the frame pulse.
module pattern_gen #(
    parameter int CORDW       = 10,
    parameter int CHANW       = 4,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SQ_SHIFT    = 4,
    parameter int CHECK_SHIFT = 5,
    parameter int SCROLL_STEP = 4
) (
    input  logic          clk_pix,
    input  logic          rst_pix_n,
    pattern_gen_if.slave  vif
);

    localparam logic [CHANW-1:0] FULL      = '1;
    localparam logic [CHANW-1:0] HALF      = CHANW'(1) << (CHANW - 1);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;
    localparam logic [CORDW-1:0] H_LIM     = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_LIM     = CORDW'(V_RES);
    localparam int               SLW       = CORDW + SQ_SHIFT + CHANW;

    // Widening first gives zero-extension when the coordinate is narrower
    // than the requested bit slice.
    function automatic logic [CHANW-1:0] slice(input logic [CORDW-1:0] v);
        logic [SLW-1:0] ext;
        ext = SLW'(v);
        return ext[SQ_SHIFT +: CHANW];
    endfunction

    logic [2:0]       mode_q, mode_d;
    logic [CORDW-1:0] offset_q, offset_d;
    logic [15:0]      lfsr_q, lfsr_d;

    logic [CHANW-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    logic             de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [CHANW-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
    logic             hs2_q, hs2_d, vs2_q, vs2_d;

    logic [6:0]       bar_ge;
    logic [2:0]       bar_idx;
    logic             in_range;
    logic [CORDW-1:0] scroll_x;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_bar
            localparam logic [CORDW-1:0] BAR_EDGE = CORDW'((gi + 1) * H_RES / 8);
            assign bar_ge[gi] = (vif.sx >= BAR_EDGE);
        end
    endgenerate

    // Edge comparisons are monotonic in sx, so the bar index is their count.
    always_comb begin
        bar_idx = '0;
        for (int k = 0; k < 7; k++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[k]};
        end
    end

    always_comb begin
        mode_d   = mode_q;
        offset_d = offset_q;
        lfsr_d   = lfsr_q;
        if (vif.frame) begin
            mode_d   = vif.mode;
            offset_d = offset_q + CORDW'(SCROLL_STEP);
            lfsr_d   = LFSR_SEED;
        end else if (vif.de && mode_q == 3'd4) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_comb begin
        in_range = (vif.sx < H_LIM) && (vif.sy < V_LIM);
        scroll_x = vif.sx + offset_q;
        r1_d     = '0;
        g1_d     = '0;
        b1_d     = '0;
        if (in_range) begin
            case (mode_q)
                3'd0: begin
                    r1_d = slice(vif.sx);
                    g1_d = slice(vif.sy);
                    b1_d = HALF;
                end
                3'd1: begin
                    // white, yellow, cyan, green, magenta, red, blue, black
                    r1_d = bar_idx[1] ? '0 : FULL;
                    g1_d = bar_idx[2] ? '0 : FULL;
                    b1_d = bar_idx[0] ? '0 : FULL;
                end
                3'd2: begin
                    if (vif.sx[CHECK_SHIFT] ^ vif.sy[CHECK_SHIFT]) begin
                        r1_d = FULL;
                        g1_d = FULL;
                        b1_d = FULL;
                    end
                end
                3'd3: begin
                    r1_d = slice(scroll_x);
                    g1_d = slice(vif.sy);
                    b1_d = HALF;
                end
                3'd4: begin
                    r1_d = lfsr_q[CHANW-1:0];
                    g1_d = lfsr_q[CHANW-1:0];
                    b1_d = lfsr_q[CHANW-1:0];
                end
                default: begin
                end
            endcase
        end
        de1_d = vif.de;
        hs1_d = vif.hsync;
        vs1_d = vif.vsync;
    end

    always_comb begin
        r2_d  = de1_q ? r1_q : '0;
        g2_d  = de1_q ? g1_q : '0;
        b2_d  = de1_q ? b1_q : '0;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
    end

    // Sync registers reset high: deasserted for negative-polarity modes.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            mode_q   <= '0;
            offset_q <= '0;
            lfsr_q   <= LFSR_SEED;
            r1_q     <= '0;
            g1_q     <= '0;
            b1_q     <= '0;
            de1_q    <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            r2_q     <= '0;
            g2_q     <= '0;
            b2_q     <= '0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
        end else begin
            mode_q   <= mode_d;
            offset_q <= offset_d;
            lfsr_q   <= lfsr_d;
            r1_q     <= r1_d;
            g1_q     <= g1_d;
            b1_q     <= b1_d;
            de1_q    <= de1_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            r2_q     <= r2_d;
            g2_q     <= g2_d;
            b2_q     <= b2_d;
            hs2_q    <= hs2_d;
            vs2_q    <= vs2_d;
        end
    end

    assign vif.vga_r     = r2_q;
    assign vif.vga_g     = g2_q;
    assign vif.vga_b     = b2_q;
    assign vif.vga_hsync = hs2_q;
    assign vif.vga_vsync = vs2_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: stimulus pushes hand-computed expected
// pixels into a scoreboard; a monitor pops them when the pipeline delivers.
module tb_pattern_gen;
    localparam int CORDW = 10;
    localparam int CHANW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pattern_gen_if #(.CORDW(CORDW), .CHANW(CHANW)) vif ();

    pattern_gen #(
        .CORDW(CORDW), .CHANW(CHANW), .H_RES(640), .V_RES(480),
        .SQ_SHIFT(4), .CHECK_SHIFT(5), .SCROLL_STEP(16)
    ) dut (
        .clk_pix   (clk),
        .rst_pix_n (rst_n),
        .vif       (vif)
    );

    typedef struct {
        int          due;
        logic [3:0]  r, g, b;
        logic        hs, vs;
        string       name;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_assert++;
            if ({vif.vga_r, vif.vga_g, vif.vga_b} !== {e.r, e.g, e.b}) begin
                n_fail++;
                $display("FAIL %s rgb: got %h,%h,%h expected %h,%h,%h",
                         e.name, vif.vga_r, vif.vga_g, vif.vga_b, e.r, e.g, e.b);
            end
            n_assert++;
            if ({vif.vga_hsync, vif.vga_vsync} !== {e.hs, e.vs}) begin
                n_fail++;
                $display("FAIL %s sync: got hs=%b vs=%b expected hs=%b vs=%b",
                         e.name, vif.vga_hsync, vif.vga_vsync, e.hs, e.vs);
            end
        end
    end

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic de,
                         input logic hs, input logic vs, input logic fr,
                         input logic [2:0] m, input logic [3:0] er,
                         input logic [3:0] eg, input logic [3:0] eb, input string nm);
        exp_t e;
        @(negedge clk);
        vif.sx = x; vif.sy = y; vif.de = de; vif.hsync = hs; vif.vsync = vs;
        vif.frame = fr; vif.mode = m;
        e.due = cyc + 2;
        e.r = de ? er : 4'h0;
        e.g = de ? eg : 4'h0;
        e.b = de ? eb : 4'h0;
        e.hs = hs; e.vs = vs; e.name = nm;
        sb.push_back(e);
        $display("drive %-12s sx=%0d sy=%0d de=%b frame=%b mode=%0d exp=%h,%h,%h",
                 nm, x, y, de, fr, m, e.r, e.g, e.b);
    endtask

    task automatic frame_pulse(input logic [2:0] m);
        drive(10'd0, 10'd500, 1'b0, 1'b1, 1'b0, 1'b1, m, 4'h0, 4'h0, 4'h0, "frame");
    endtask

    task automatic flush();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge clk);
            vif.de = 1'b0; vif.frame = 1'b0; vif.hsync = 1'b1; vif.vsync = 1'b1;
            n++;
        end
        if (sb.size() > 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL flush: %0d entries still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset(input string nm);
        n_assert++;
        if ({vif.vga_r, vif.vga_g, vif.vga_b, vif.vga_hsync, vif.vga_vsync} !== {12'h000, 2'b11}) begin
            n_fail++;
            $display("FAIL %s: got rgb=%h,%h,%h hs=%b vs=%b expected 0,0,0 hs=1 vs=1",
                     nm, vif.vga_r, vif.vga_g, vif.vga_b, vif.vga_hsync, vif.vga_vsync);
        end else begin
            $display("check %s ok", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hs_pat;
        logic [7:0] vs_pat;
        logic [3:0] noise[7];
        logic       noise_de[7];
        hs_pat = 8'b1011_0010;
        vs_pat = 8'b0110_1101;
        noise  = '{4'h1, 4'h0, 4'h8, 4'h0, 4'hC, 4'hE, 4'h7};
        noise_de = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        vif.sx = 10'h35; vif.sy = 10'h2A; vif.de = 1'b1; vif.hsync = 1'b0;
        vif.vsync = 1'b0; vif.frame = 1'b0; vif.mode = 3'd2;
        repeat (4) @(negedge clk);
        check_reset("reset_hold");
        rst_n = 1'b1;

        // Square mode out of reset even though mode input is non-zero.
        drive(10'h35, 10'h2A, 1, 1, 1, 0, 3'd2, 4'h3, 4'h2, 4'h8, "rst_first");
        drive(10'h1F0, 10'h10, 1, 0, 1, 0, 3'd2, 4'hF, 4'h1, 4'h8, "square_b");
        drive(10'd700, 10'd0, 1, 1, 0, 0, 3'd2, 4'h0, 4'h0, 4'h0, "sq_out_x");
        drive(10'd16, 10'd480, 1, 1, 1, 0, 3'd2, 4'h0, 4'h0, 4'h0, "sq_out_y");
        drive(10'd32, 10'd0, 1, 1, 1, 0, 3'd2, 4'h2, 4'h0, 4'h8, "latch_hold");
        drive(10'h35, 10'h2A, 0, 1, 1, 0, 3'd2, 4'h0, 4'h0, 4'h0, "blank");

        frame_pulse(3'd2);
        drive(10'd32, 10'd0, 1, 1, 1, 0, 3'd0, 4'hF, 4'hF, 4'hF, "chk_a");
        drive(10'd32, 10'd32, 1, 1, 1, 0, 3'd0, 4'h0, 4'h0, 4'h0, "chk_b");
        drive(10'd0, 10'd32, 1, 1, 1, 0, 3'd0, 4'hF, 4'hF, 4'hF, "chk_c");
        drive(10'd31, 10'd0, 1, 1, 1, 0, 3'd0, 4'h0, 4'h0, 4'h0, "chk_d");

        // Frame coinciding with an active pixel: pixel still sees checker.
        drive(10'h35, 10'h2A, 1, 1, 1, 1, 3'd1, 4'h0, 4'h0, 4'h0, "simul");
        drive(10'd79, 10'd0, 1, 1, 1, 0, 3'd0, 4'hF, 4'hF, 4'hF, "bar_79");
        drive(10'd80, 10'd0, 1, 1, 1, 0, 3'd0, 4'hF, 4'hF, 4'h0, "bar_80");
        drive(10'd240, 10'd0, 1, 1, 1, 0, 3'd0, 4'h0, 4'hF, 4'h0, "bar_240");
        drive(10'd400, 10'd0, 1, 1, 1, 0, 3'd0, 4'hF, 4'h0, 4'h0, "bar_400");
        drive(10'd559, 10'd0, 1, 1, 1, 0, 3'd0, 4'h0, 4'h0, 4'hF, "bar_559");
        drive(10'd560, 10'd0, 1, 1, 1, 0, 3'd0, 4'h0, 4'h0, 4'h0, "bar_560");
        drive(10'd639, 10'd0, 1, 1, 1, 0, 3'd0, 4'h0, 4'h0, 4'h0, "bar_639");
        drive(10'd700, 10'd0, 1, 1, 1, 0, 3'd0, 4'h0, 4'h0, 4'h0, "bar_700");
        flush();

        // Asynchronous reset mid-frame, checked before any clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        drive(10'h35, 10'h2A, 1, 1, 1, 0, 3'd1, 4'h3, 4'h2, 4'h8, "rst_mode0");

        repeat (3) frame_pulse(3'd3);
        drive(10'd0, 10'd0, 1, 1, 1, 0, 3'd0, 4'h3, 4'h0, 4'h8, "scroll_48a");
        drive(10'd20, 10'h2A, 1, 1, 1, 0, 3'd0, 4'h4, 4'h2, 4'h8, "scroll_48b");
        drive(10'd630, 10'd0, 1, 1, 1, 0, 3'd0, 4'hA, 4'h0, 4'h8, "scroll_48c");
        repeat (60) frame_pulse(3'd3);
        drive(10'd0, 10'd0, 1, 1, 1, 0, 3'd0, 4'hF, 4'h0, 4'h8, "scroll_1008");
        frame_pulse(3'd3);
        drive(10'd0, 10'd0, 1, 1, 1, 0, 3'd0, 4'h0, 4'h0, 4'h8, "scroll_wrap");
        drive(10'd600, 10'd0, 1, 1, 1, 0, 3'd0, 4'h5, 4'h0, 4'h8, "scroll_600");

        // Same noise sequence in two frames; de=0 gap must not step the LFSR.
        for (int f = 0; f < 2; f++) begin
            frame_pulse(3'd4);
            for (int i = 0; i < 7; i++) begin
                drive(10'(i), 10'd0, noise_de[i], hs_pat[i], vs_pat[i], 0, 3'd0,
                      noise[i], noise[i], noise[i], $sformatf("noise_f%0d_%0d", f, i));
            end
            drive(10'd7, 10'd0, 1, 1, 1, 0, 3'd0, 4'h3, 4'h3, 4'h3,
                  $sformatf("noise_f%0d_7", f));
        end

        for (int i = 0; i < 8; i++) begin
            drive(10'd0, 10'd0, 0, hs_pat[i], vs_pat[i], 0, 3'd0, 4'h0, 4'h0, 4'h0,
                  $sformatf("sync_%0d", i));
        end

        frame_pulse(3'd5);
        drive(10'h35, 10'h2A, 1, 1, 1, 0, 3'd0, 4'h0, 4'h0, 4'h0, "mode5");
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
